// File: rtl/demux_1_8_stream_if.sv
// Producer/consumer bundle for demux_1_8_stream. Defining DEMUX_BROADCAST_EN
// adds the in_bcast request line.
interface demux_1_8_stream_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0]   in_data;
  logic [2:0]          in_sel;
  logic                in_valid;
  logic                in_ready;
`ifdef DEMUX_BROADCAST_EN
  logic                in_bcast;
`endif
  logic [8*DATA_W-1:0] out_data;
  logic [7:0]          out_valid;
  logic [7:0]          out_ready;

  // The master side plays both the producer and the eight consumers.
  modport master (
`ifdef DEMUX_BROADCAST_EN
    output in_bcast,
`endif
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
`ifdef DEMUX_BROADCAST_EN
    input  in_bcast,
`endif
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_1_8_stream.sv
// Registered 1-to-8 stream demultiplexer with one holding register per lane.
// Defining DEMUX_BROADCAST_EN lets a single accepted word load all eight lanes.
module demux_1_8_stream #(
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  demux_1_8_stream_if.slave  bus,
  output logic [COUNT_W-1:0] xfer_count
);

  logic [7:0]              laneValid;
  logic [7:0][DATA_W-1:0]  laneData;
  logic [7:0]              laneFree;
  logic [7:0]              laneLoad;
  logic                    acc;

  // A lane can take a word if it is empty or is draining this same cycle.
  assign laneFree = ~laneValid | bus.out_ready;

`ifdef DEMUX_BROADCAST_EN
  assign bus.in_ready = bus.in_bcast ? (&laneFree) : laneFree[bus.in_sel];
`else
  assign bus.in_ready = laneFree[bus.in_sel];
`endif

  assign acc = bus.in_valid & bus.in_ready;

  always_comb begin
    laneLoad = '0;
    for (int k = 0; k < 8; k++) begin
      laneLoad[k] = acc & (bus.in_sel == 3'(k));
    end
`ifdef DEMUX_BROADCAST_EN
    if (acc & bus.in_bcast) begin
      laneLoad = '1;
    end
`endif
  end

  // A load wins over a drain, so a full lane can be refilled without a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      laneValid <= '0;
      laneData  <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (laneLoad[k]) begin
          laneData[k]  <= bus.in_data;
          laneValid[k] <= 1'b1;
        end else if (bus.out_ready[k]) begin
          laneValid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count <= '0;
    end else if (acc) begin
      xfer_count <= xfer_count + COUNT_W'(1);
    end
  end

  assign bus.out_valid = laneValid;
  assign bus.out_data  = laneData;

endmodule

// File: tb/tb_demux_1_8_stream.sv
// Scoreboard bench for demux_1_8_stream: accepted words are queued as expected
// lane contents and a negedge monitor checks every drain against that queue.
module tb_demux_1_8_stream;

  localparam int DATA_W  = 16;
  localparam int COUNT_W = 4;

  typedef struct {
    logic [2:0]        sel;
    logic [DATA_W-1:0] data;
  } expT;

  logic               clock;
  logic               reset_n;
  logic [COUNT_W-1:0] xfer_count;
  logic [COUNT_W-1:0] expCount;
  expT                expQ[$];
  int                 total;
  int                 bad;

  demux_1_8_stream_if #(.DATA_W(DATA_W)) bus ();

  demux_1_8_stream #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .xfer_count (xfer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Offers one unicast word, waits (bounded) for acceptance, records the expectation.
  task automatic applyStimulus(input logic [2:0] sel, input logic [DATA_W-1:0] data);
    bit taken;
    expT e;
    taken        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clock);
      if (bus.in_ready) taken = 1'b1;
    end
    if (!taken) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout sel=%0d actual=no_accept required=accept", sel);
    end else begin
      e.sel  = sel;
      e.data = data;
      expQ.push_back(e);
      expCount = expCount + 1'b1;
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    int idx;
    if (reset_n) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          idx = -1;
          for (int i = 0; i < expQ.size(); i++) begin
            if (idx < 0 && expQ[i].sel == 3'(k)) idx = i;
          end
          if (idx < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_lane%0d actual=unexpected_word required=none", k);
          end else begin
            checkOutput($sformatf("drain_lane%0d", k), 32'(bus.out_data[k*DATA_W +: DATA_W]),
                        32'(expQ[idx].data));
            expQ.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total        = 0;
    bad          = 0;
    expCount     = '0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd0;
    bus.in_data  = 16'h5555;
    bus.out_ready = 8'h00;
`ifdef DEMUX_BROADCAST_EN
    bus.in_bcast = 1'b0;
`endif

    // Reset held with a valid offer present: nothing may be accepted.
    repeat (2) @(negedge clock);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h00);
    checkOutput("reset_xfer_count", 32'(xfer_count), 32'h0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h1);
    bus.in_valid = 1'b0;
    reset_n      = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'h1);

    // Single route to lane 5.
    @(posedge clock); #1;
    applyStimulus(3'd5, 16'hA5A5);
    @(negedge clock);
    checkOutput("route_out_valid", 32'(bus.out_valid), 32'h20);
    checkOutput("route_lane5", 32'(bus.out_data[5*DATA_W +: DATA_W]), 32'hA5A5);
    checkOutput("route_xfer_count", 32'(xfer_count), 32'h1);

    // Backpressure on lane 5, then pass-through once the consumer is ready.
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd5;
    bus.in_data  = 16'h1234;
    @(negedge clock);
    checkOutput("stall_in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("stall_lane5_hold", 32'(bus.out_data[5*DATA_W +: DATA_W]), 32'hA5A5);
    @(posedge clock); #1;
    checkOutput("stall_lane5_hold2", 32'(bus.out_data[5*DATA_W +: DATA_W]), 32'hA5A5);
    bus.out_ready = 8'h20;
    applyStimulus(3'd5, 16'h1234);
    bus.out_ready = 8'h00;
    @(negedge clock);
    checkOutput("passthru_out_valid", 32'(bus.out_valid), 32'h20);
    checkOutput("passthru_lane5", 32'(bus.out_data[5*DATA_W +: DATA_W]), 32'h1234);
    checkOutput("passthru_xfer_count", 32'(xfer_count), 32'h2);

    // Independence: lane 2 loads while lane 5 is stalled, then both drain.
    @(posedge clock); #1;
    applyStimulus(3'd2, 16'h00FF);
    @(negedge clock);
    checkOutput("indep_out_valid", 32'(bus.out_valid), 32'h24);
    checkOutput("indep_lane5_hold", 32'(bus.out_data[5*DATA_W +: DATA_W]), 32'h1234);
    @(posedge clock); #1;
    bus.out_ready = 8'h24;
    @(posedge clock); #1;
    bus.out_ready = 8'h00;
    @(negedge clock);
    checkOutput("both_drained", 32'(bus.out_valid), 32'h00);

    // Counter wrap with all consumers ready.
    @(posedge clock); #1;
    bus.out_ready = 8'hFF;
    for (int i = 0; i < 12; i++) applyStimulus(3'(i % 8), 16'(16'h1000 + i));
    checkOutput("count_15", 32'(xfer_count), 32'd15);
    applyStimulus(3'd6, 16'h2016);
    checkOutput("count_wrap_0", 32'(xfer_count), 32'd0);
    applyStimulus(3'd7, 16'h2017);
    checkOutput("count_wrap_1", 32'(xfer_count), 32'd1);
    @(negedge clock);
    @(posedge clock); #1;
    bus.out_ready = 8'h00;

    // Fill lanes 0, 3, 7 and reset asynchronously between edges.
    applyStimulus(3'd0, 16'hAAA0);
    applyStimulus(3'd3, 16'hAAA3);
    applyStimulus(3'd7, 16'hAAA7);
    @(negedge clock);
    checkOutput("fill_out_valid", 32'(bus.out_valid), 32'h89);
    checkOutput("fill_xfer_count", 32'(xfer_count), 32'd4);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 32'(bus.out_valid), 32'h00);
    checkOutput("async_reset_count", 32'(xfer_count), 32'h0);
    checkOutput("async_reset_lane3", 32'(bus.out_data[3*DATA_W +: DATA_W]), 32'h0);
    expQ.delete();
    expCount = '0;
    #1;
    reset_n = 1'b1;

`ifdef DEMUX_BROADCAST_EN
    @(posedge clock); #1;
    bus.in_bcast = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd6;
    bus.in_data  = 16'hBEEF;
    @(negedge clock);
    checkOutput("bcast_in_ready", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      expQ.push_back('{sel: 3'(k), data: 16'hBEEF});
    end
    expCount = expCount + 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    @(negedge clock);
    checkOutput("bcast_out_valid", 32'(bus.out_valid), 32'hFF);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("bcast_lane%0d", k), 32'(bus.out_data[k*DATA_W +: DATA_W]), 32'hBEEF);
    end
    checkOutput("bcast_xfer_count", 32'(xfer_count), 32'h1);
`endif

    // Drain whatever is left and confirm the scoreboard emptied.
    @(posedge clock); #1;
    bus.out_ready = 8'hFF;
    repeat (2) @(negedge clock);
    checkOutput("final_out_valid", 32'(bus.out_valid), 32'h00);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    checkOutput("final_xfer_count", 32'(xfer_count), 32'(expCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
